// File: rtl/riscv_control_fsm.sv
// riscv_control_fsm
//   Multi-cycle main control FSM for the RV32I core. It latches each fetched
//   instruction into IR and then steps through fetch, decode, execute, memory
//   and writeback. It drives alu_ctrl, funct3 and funct7_5 to the ALU control
//   decoder, and it drives the datapath operand/result selects and enables.
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   fetch_req / fetch_ack      instruction fetch handshake, instr is the word
//   mem_req / mem_we / mem_ack data access handshake (mem_we=1 store)
//   alu_zero, alu_lt, alu_ltu  ALU flags used to resolve branches
//   alu_ctrl                   00 NOP, 01 ADD, 10 SUB, 11 FUNCT
//   funct3, funct7_5           instruction fields for the ALU decoder
//   alu_src_a, alu_src_b       operand selects
//   result_src                 register file write-data select
//   reg_write, pc_write        single-cycle write enables
//   illegal                    sticky flag for an unsupported instruction
module riscv_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic [31:0] instr,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  output logic [1:0]  alu_ctrl,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        reg_write,
  output logic        pc_write,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_ACC, S_WB_ALU,
    S_WB_MEM, S_BRANCH, S_BR_TGT, S_JUMP, S_UPPER, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_NOP   = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b10;
  localparam logic [1:0] ALU_FUNCT = 2'b11;

  state_t      state, state_next;
  logic [31:0] ir;
  logic        illegal_q;
  logic        first_fetch;
  logic        br_taken;
  logic        br_bad;

  // The reset PC is applied by the PC register itself; only the pc_write
  // pulse of the first fetch is generated here.
  logic unused_bits;
  assign unused_bits = ^{RESET_PC, ir[31], ir[29:15], ir[11:7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      ir          <= 32'h0000_0013;
      illegal_q   <= 1'b0;
      first_fetch <= 1'b1;
    end else begin
      state       <= state_next;
      first_fetch <= 1'b0;
      if (state == S_FETCH && fetch_ack) ir <= instr;
      if (state_next == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (ir[14:12])
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = ~alu_zero;
      3'b100:  br_taken = alu_lt;
      3'b101:  br_taken = ~alu_lt;
      3'b110:  br_taken = alu_ltu;
      3'b111:  br_taken = ~alu_ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    fetch_req  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    alu_ctrl   = ALU_NOP;
    funct3     = ir[14:12];
    funct7_5   = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    result_src = 2'd0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    illegal    = illegal_q;
    case (state)
      S_FETCH: begin
        fetch_req = 1'b1;
        pc_write  = first_fetch;
        if (fetch_ack) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (ir[6:0])
          OP_R:              state_next = S_EXEC_R;
          OP_IMM:            state_next = S_EXEC_I;
          OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL, OP_JALR:   state_next = S_JUMP;
          OP_LUI, OP_AUIPC:  state_next = S_UPPER;
          default:           state_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_ctrl   = ALU_FUNCT;
        funct7_5   = ir[30];
        state_next = S_WB_ALU;
      end
      S_EXEC_I: begin
        // Only shifts carry a meaningful bit 30; for addi etc. it is immediate.
        alu_ctrl   = ALU_FUNCT;
        alu_src_b  = 2'd1;
        funct7_5   = (ir[14:12] == 3'b101) ? ir[30] : 1'b0;
        state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_ctrl   = ALU_ADD;
        alu_src_b  = 2'd1;
        state_next = S_MEM_ACC;
      end
      S_MEM_ACC: begin
        // Bit 5 separates STORE from LOAD.
        mem_req = 1'b1;
        mem_we  = ir[5];
        if (mem_ack) begin
          pc_write   = ir[5];
          state_next = ir[5] ? S_FETCH : S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        result_src = 2'd1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_ctrl = ALU_SUB;
        if (br_bad) begin
          state_next = S_TRAP;
        end else if (br_taken) begin
          state_next = S_BR_TGT;
        end else begin
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_BR_TGT: begin
        alu_ctrl   = ALU_ADD;
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd1;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        // Bit 3 separates JAL (PC-relative) from JALR (rs1-relative).
        alu_ctrl   = ALU_ADD;
        alu_src_a  = ir[3] ? 2'd1 : 2'd0;
        alu_src_b  = 2'd1;
        result_src = 2'd2;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      S_UPPER: begin
        // Bit 5 separates LUI (zero base) from AUIPC (PC base).
        alu_ctrl   = ALU_ADD;
        alu_src_a  = ir[5] ? 2'd2 : 2'd1;
        alu_src_b  = 2'd1;
        state_next = S_WB_ALU;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
    // While reset is held, all outputs are quiet so no request or write leaks.
    if (reset) begin
      fetch_req  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      alu_ctrl   = ALU_NOP;
      funct3     = 3'b000;
      funct7_5   = 1'b0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      result_src = 2'd0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_control_fsm.sv
// tb_riscv_control_fsm
//   Drives instructions through the control FSM with random ack delays, random
//   ALU flags and spurious acks, and compares every cycle's outputs with the
//   output sequence each instruction class should produce.
module tb_riscv_control_fsm;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req, fetch_ack = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  logic [1:0]  alu_ctrl, alu_src_a, alu_src_b, result_src;
  logic [2:0]  funct3;
  logic        funct7_5, reg_write, pc_write, illegal;

  riscv_control_fsm #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .instr(instr), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .alu_ctrl(alu_ctrl), .funct3(funct3), .funct7_5(funct7_5),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .reg_write(reg_write), .pc_write(pc_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_ir = 32'h13;
  logic        model_ill = 1'b0;
  logic        model_first = 1'b1;

  logic [17:0] dut_vec;
  assign dut_vec = {fetch_req, mem_req, mem_we, alu_ctrl, funct3, funct7_5,
                    alu_src_a, alu_src_b, result_src, reg_write, pc_write, illegal};

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (fr mr mw alu f3 f75 sa sb rs rw pw ill)",
               tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ev(input logic fr, input logic mr, input logic mw,
                                     input logic [1:0] ac, input logic f75,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic rw,
                                     input logic pw);
    return {fr, mr, mw, ac, model_ir[14:12], f75, sa, sb, rs, rw, pw, model_ill};
  endfunction

  // Called at a falling edge with inputs applied; checks, then moves one cycle.
  task automatic tick(input logic [17:0] e, input string tag);
    #1;
    check(tag, dut_vec, e);
    @(negedge clk);
  endtask

  task automatic noise();
    fetch_ack = 1'($urandom);
    mem_ack   = 1'($urandom);
    instr     = $urandom;
    alu_zero  = 1'($urandom);
    alu_lt    = 1'($urandom);
    alu_ltu   = 1'($urandom);
  endtask

  task automatic do_reset();
    noise();
    reset = 1'b1;
    tick(18'h0, "reset");
    reset = 1'b0;
    model_ir = 32'h13;
    model_ill = 1'b0;
    model_first = 1'b1;
  endtask

  task automatic trap_then_reset();
    model_ill = 1'b1;
    for (int i = 0; i < 3; i++) begin
      noise();
      tick(ev(0,0,0,2'd0,0,2'd0,2'd0,2'd0,0,0), "trap");
    end
    do_reset();
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic z, input logic lt, input logic ltu,
                           input bit abort_mem);
    logic [6:0] op;
    logic [2:0] f3;
    logic       st;
    logic       taken;
    op = ins[6:0];
    f3 = ins[14:12];
    for (int i = 0; i < fw; i++) begin
      noise();
      fetch_ack = 1'b0;
      tick(ev(1,0,0,2'd0,0,2'd0,2'd0,2'd0,0,model_first), "fetch_wait");
      model_first = 1'b0;
    end
    noise();
    fetch_ack = 1'b1;
    instr = ins;
    tick(ev(1,0,0,2'd0,0,2'd0,2'd0,2'd0,0,model_first), "fetch_ack");
    model_first = 1'b0;
    model_ir = ins;
    noise();
    tick(ev(0,0,0,2'd0,0,2'd0,2'd0,2'd0,0,0), "decode");
    noise();
    if (!is_legal(op)) begin
      trap_then_reset();
    end else if (op == 7'b0110011 || op == 7'b0010011 ||
                 op == 7'b0110111 || op == 7'b0010111) begin
      if (op == 7'b0110011)
        tick(ev(0,0,0,2'd3,ins[30],2'd0,2'd0,2'd0,0,0), "exec_r");
      else if (op == 7'b0010011)
        tick(ev(0,0,0,2'd3,(f3 == 3'b101) ? ins[30] : 1'b0,2'd0,2'd1,2'd0,0,0), "exec_i");
      else
        tick(ev(0,0,0,2'd1,0,(op == 7'b0110111) ? 2'd2 : 2'd1,2'd1,2'd0,0,0), "upper");
      noise();
      tick(ev(0,0,0,2'd0,0,2'd0,2'd0,2'd0,1,1), "wb_alu");
    end else if (op == 7'b0000011 || op == 7'b0100011) begin
      st = (op == 7'b0100011);
      tick(ev(0,0,0,2'd1,0,2'd0,2'd1,2'd0,0,0), "mem_addr");
      for (int i = 0; i < mw; i++) begin
        noise();
        mem_ack = 1'b0;
        if (abort_mem && i == 1) begin
          reset = 1'b1;
          tick(18'h0, "rst_mem_acc");
          reset = 1'b0;
          model_ir = 32'h13;
          model_ill = 1'b0;
          model_first = 1'b1;
          return;
        end
        tick(ev(0,1,st,2'd0,0,2'd0,2'd0,2'd0,0,0), "mem_wait");
      end
      noise();
      mem_ack = 1'b1;
      tick(ev(0,1,st,2'd0,0,2'd0,2'd0,2'd0,0,st), "mem_ack");
      if (!st) begin
        noise();
        tick(ev(0,0,0,2'd0,0,2'd0,2'd0,2'd1,1,1), "wb_mem");
      end
    end else if (op == 7'b1100011) begin
      alu_zero = z; alu_lt = lt; alu_ltu = ltu;
      case (f3)
        3'b000: taken = z;
        3'b001: taken = !z;
        3'b100: taken = lt;
        3'b101: taken = !lt;
        3'b110: taken = ltu;
        3'b111: taken = !ltu;
        default: taken = 1'b0;
      endcase
      if (f3 == 3'b010 || f3 == 3'b011) begin
        tick(ev(0,0,0,2'd2,0,2'd0,2'd0,2'd0,0,0), "branch_bad");
        trap_then_reset();
      end else begin
        tick(ev(0,0,0,2'd2,0,2'd0,2'd0,2'd0,0,!taken), "branch");
        if (taken) begin
          noise();
          tick(ev(0,0,0,2'd1,0,2'd1,2'd1,2'd0,0,1), "br_tgt");
        end
      end
    end else begin
      tick(ev(0,0,0,2'd1,0,(op == 7'b1101111) ? 2'd1 : 2'd0,2'd1,2'd2,1,1), "jump");
    end
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    int          cls;
    @(negedge clk);
    do_reset();
    run_instr(32'h002081B3, 0, 0, 0, 0, 0, 0);  // add
    run_instr(32'h80000093, 1, 0, 0, 0, 0, 0);  // addi -2048
    run_instr(32'h4030D093, 0, 0, 0, 0, 0, 0);  // srai
    run_instr(32'h40208133, 0, 0, 0, 0, 0, 0);  // sub
    run_instr(32'h0000A083, 2, 3, 0, 0, 0, 0);  // lw, 3-cycle ack delay
    run_instr(32'h0020A023, 0, 1, 0, 0, 0, 0);  // sw
    run_instr(32'h00208063, 0, 0, 1, 0, 0, 0);  // beq taken
    run_instr(32'h00209063, 0, 0, 1, 0, 0, 0);  // bne not taken
    run_instr(32'h0000006F, 0, 0, 0, 0, 0, 0);  // jal
    run_instr(32'h00008067, 0, 0, 0, 0, 0, 0);  // jalr
    run_instr(32'h000010B7, 0, 0, 0, 0, 0, 0);  // lui
    run_instr(32'h00001097, 0, 0, 0, 0, 0, 0);  // auipc
    run_instr(32'h0000A083, 0, 3, 0, 0, 0, 1);  // lw, reset during MEM_ACC
    run_instr(32'h0020A083, 0, 0, 0, 0, 0, 0);
    run_instr(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);  // opcode 1111111
    run_instr(32'h0020A063, 0, 0, 0, 0, 0, 0);  // branch funct3=010
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      cls = $urandom_range(0, 10);
      case (cls)
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4, 5: op = 7'b1100011;
        6: op = 7'b1101111;
        7: op = 7'b1100111;
        8: op = 7'b0110111;
        9: op = 7'b0010111;
        default: begin
          op = 7'h7F;
          for (int k = 0; k < 50; k++) begin
            op = 7'($urandom);
            if (!is_legal(op)) break;
          end
          if (is_legal(op)) op = 7'h7F;
        end
      endcase
      ins[6:0] = op;
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
